// File: rtl/datamem_pkg.sv
// Shared types and constants for the datamem_responder slice: FSM encoding,
// default geometry/latency and the big-endian byte-lane order.
package datamem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int DEF_DEPTH      = 32;
   localparam int DEF_AW         = 5;
   localparam int DEF_LATENCY    = 2;
   localparam int BYTES_PER_WORD = 4;

   // Lane k lives at byte address a+k; with big-endian order lane 0 is bits 31:24.
   localparam bit BIG_ENDIAN = 1'b1;

   function automatic int laneShift(input int k);
      return BIG_ENDIAN ? 8 * (BYTES_PER_WORD - 1 - k) : 8 * k;
   endfunction

endpackage

// File: rtl/datamem_bytearray.sv
// DEPTH x 8 byte storage with a 4-byte word port; lane addresses wrap modulo DEPTH.
// Contents are intentionally not reset.
module datamem_bytearray
   import datamem_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] laneAddr [BYTES_PER_WORD];

   // AW-bit addition gives the wrap-around for free.
   always_comb begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         laneAddr[k] = addr_i + AW'(k);
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         rdata_o[laneShift(k) +: 8] = mem_q[laneAddr[k]];
      end
   end

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int k = 0; k < BYTES_PER_WORD; k++) begin
            mem_q[laneAddr[k]] <= wdata_i[laneShift(k) +: 8];
         end
      end
   end

endmodule

// File: rtl/datamem_responder.sv
// Multi-cycle data-memory responder with programmable wait states.
// Optional alignment/range checking is enabled by defining DATAMEM_ALIGN_CHECK_EN.
module datamem_responder
   import datamem_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int AW      = DEF_AW,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          write_q, err_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q, rdata_d;
   logic          rspErr_q, rspErr_d;

   logic          accept, doAccess, accWrite, accErr, reqErr, arrWe;
   logic [AW-1:0] accAddr;
   logic [31:0]   accWdata, arrRdata;

`ifdef DATAMEM_ALIGN_CHECK_EN
   assign reqErr = (req_addr[1:0] != 2'b00) || (req_addr[31:AW] != '0);
`else
   logic unusedAddrBits;
   assign unusedAddrBits = ^req_addr[31:AW];
   assign reqErr         = 1'b0;
`endif

   // With zero latency the access happens on the accept edge itself, so the
   // access operands come straight from the request inputs in that case.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      rspErr_d  = rspErr_q;
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      accept    = req_valid && req_ready;
      doAccess  = 1'b0;
      accWrite  = write_q;
      accAddr   = addr_q;
      accWdata  = wdata_q;
      accErr    = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  doAccess = 1'b1;
                  accWrite = req_write;
                  accAddr  = req_addr[AW-1:0];
                  accWdata = req_wdata;
                  accErr   = reqErr;
                  state_d  = RESP;
               end else begin
                  cnt_d   = 4'(LATENCY - 1);
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               doAccess = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d  = IDLE;
               rdata_d  = '0;
               rspErr_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (doAccess) begin
         rdata_d  = (accWrite || accErr) ? 32'd0 : arrRdata;
         rspErr_d = accErr;
      end
   end

   assign arrWe     = doAccess && accWrite && !accErr;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = rspErr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rspErr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         rspErr_q <= rspErr_d;
         if (accept) begin
            write_q <= req_write;
            err_q   <= reqErr;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
         end
      end
   end

   datamem_bytearray #(
      .DEPTH(DEPTH),
      .AW   (AW)
   ) u_bytearray (
      .clk_i  (clk),
      .we_i   (arrWe),
      .addr_i (accAddr),
      .wdata_i(accWdata),
      .rdata_o(arrRdata)
   );

endmodule

// File: tb/tb_datamem_responder.sv
// Bench for datamem_responder: one LATENCY=2 and one LATENCY=0 instance, random
// traffic checked against a byte-array reference model.
module tb_datamem_responder;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        sel0 = 1'b0;
   logic        reqValid = 1'b0, reqWrite = 1'b0, rspReady = 1'b0;
   logic [31:0] reqAddr = '0, reqWdata = '0;

   logic        reqReady2, rspValid2, rspErr2, reqReady0, rspValid0, rspErr0;
   logic [31:0] rspRdata2, rspRdata0;
   logic        reqReadyM, rspValidM, rspErrM;
   logic [31:0] rspRdataM;

   int total = 0;
   int bad   = 0;
   logic [7:0] refMem [2][32];

   always #5 clk = ~clk;

   datamem_responder #(.DEPTH(32), .AW(5), .LATENCY(2)) dut (
      .clk(clk), .rst_n(rstN), .req_valid(reqValid && !sel0), .req_ready(reqReady2),
      .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
      .rsp_valid(rspValid2), .rsp_ready(rspReady), .rsp_rdata(rspRdata2), .rsp_err(rspErr2));

   datamem_responder #(.DEPTH(32), .AW(5), .LATENCY(0)) dut0 (
      .clk(clk), .rst_n(rstN), .req_valid(reqValid && sel0), .req_ready(reqReady0),
      .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
      .rsp_valid(rspValid0), .rsp_ready(rspReady), .rsp_rdata(rspRdata0), .rsp_err(rspErr0));

   assign reqReadyM = sel0 ? reqReady0 : reqReady2;
   assign rspValidM = sel0 ? rspValid0 : rspValid2;
   assign rspRdataM = sel0 ? rspRdata0 : rspRdata2;
   assign rspErrM   = sel0 ? rspErr0   : rspErr2;

   function automatic int curLat();
      return sel0 ? 0 : 2;
   endfunction

   function automatic logic alignErr(input logic [31:0] a);
`ifdef DATAMEM_ALIGN_CHECK_EN
      return (a % 4 != 0) || (a >= 32);
`else
      return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
   endfunction

   function automatic logic [31:0] modelRead(input int idx, input logic [31:0] a);
      logic [31:0] r = '0;
      for (int k = 0; k < 4; k++) r = (r << 8) | 32'(refMem[idx][(a % 32 + k) % 32]);
      return r;
   endfunction

   task automatic modelWrite(input int idx, input logic [31:0] a, input logic [31:0] d);
      if (!alignErr(a))
         for (int k = 0; k < 4; k++) refMem[idx][(a % 32 + k) % 32] = 8'(d >> (8 * (3 - k)));
   endtask

   // Drives one transaction on the selected instance and returns what it saw.
   task automatic applyTxn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int stall, output logic [31:0] rdata, output logic err,
                           output int lat);
      int n = 0;
      int idx = sel0 ? 1 : 0;
      logic [31:0] expRd;
      logic expErr;
      rdata = '0; err = 1'b0; lat = 0;
      expErr = alignErr(addr);
      expRd  = (wr || expErr) ? 32'd0 : modelRead(idx, addr);
      @(negedge clk);
      reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqWdata = wdata;
      while (!reqReadyM && n < 20) begin @(negedge clk); n++; end
      total++;
      if (reqReadyM !== 1'b1) begin
         bad++; $display("[TB] FAIL req_ready_timeout got=%b want=1", reqReadyM);
         reqValid = 1'b0; return;
      end
      @(posedge clk); #1;
      reqValid = 1'b0; reqWrite = ~wr; reqAddr = $urandom; reqWdata = $urandom;
      if (wr) modelWrite(idx, addr, wdata);
      do begin @(negedge clk); lat++; end while (!rspValidM && lat < 40);
      total++;
      if (rspValidM !== 1'b1) begin
         bad++; $display("[TB] FAIL rsp_valid_timeout got=%b want=1", rspValidM); return;
      end
      rdata = rspRdataM; err = rspErrM;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         total++;
         if (rspValidM !== 1'b1 || rspRdataM !== expRd || rspErrM !== expErr || reqReadyM !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_hold v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                     rspValidM, rspRdataM, rspErrM, reqReadyM, expRd, expErr);
         end
      end
      rspReady = 1'b1;
      @(posedge clk); #1 rspReady = 1'b0;
      @(negedge clk);
      total++;
      if (rspValidM !== 1'b0 || reqReadyM !== 1'b1 || rspRdataM !== 32'd0) begin
         bad++;
         $display("[TB] FAIL after_handshake v=%b rdy=%b d=%h want v=0 rdy=1 d=0",
                  rspValidM, reqReadyM, rspRdataM);
      end
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({reqReady2, rspValid2, rspErr2, rspRdata2} !== {3'b100, 32'd0}) begin
         bad++; $display("[TB] FAIL reset_l2 rdy=%b v=%b e=%b d=%h want 1 0 0 0",
                         reqReady2, rspValid2, rspErr2, rspRdata2);
      end
      total++;
      if ({reqReady0, rspValid0, rspErr0, rspRdata0} !== {3'b100, 32'd0}) begin
         bad++; $display("[TB] FAIL reset_l0 rdy=%b v=%b e=%b d=%h want 1 0 0 0",
                         reqReady0, rspValid0, rspErr0, rspRdata0);
      end
      @(negedge clk); @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic initMem();
      logic [31:0] d; logic e; int l;
      for (int s = 0; s < 2; s++) begin
         sel0 = (s == 1);
         for (int w = 0; w < 8; w++) applyTxn(1'b1, 32'(w * 4), $urandom, 0, d, e, l);
      end
      sel0 = 1'b0;
   endtask

   task automatic test_store_load();
      logic [31:0] d; logic e; int l;
      logic [31:0] want = 32'hDEADBEEF;
      sel0 = 1'b0;
      applyTxn(1'b1, 32'h08, want, 0, d, e, l);
      total++;
      if (l !== 3 || d !== 32'd0 || e !== 1'b0) begin
         bad++; $display("[TB] FAIL store_rsp lat=%0d d=%h e=%b want 3 0 0", l, d, e);
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (dut.u_bytearray.mem_q[8 + k] !== 8'(want >> (8 * (3 - k)))) begin
            bad++; $display("[TB] FAIL store_byte%0d got=%h want=%h", k,
                            dut.u_bytearray.mem_q[8 + k], 8'(want >> (8 * (3 - k))));
         end
      end
      applyTxn(1'b0, 32'h08, 32'd0, 0, d, e, l);
      total++;
      if (l !== 3 || d !== 32'hDEADBEEF) begin
         bad++; $display("[TB] FAIL load_rsp lat=%0d d=%h want 3 deadbeef", l, d);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] d; logic e; int l;
      logic [7:0] exp8 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      int addrs [4] = '{30, 31, 0, 1};
      sel0 = 1'b0;
      applyTxn(1'b1, 32'd30, 32'h11223344, 0, d, e, l);
`ifdef DATAMEM_ALIGN_CHECK_EN
      total++;
      if (e !== 1'b1) begin bad++; $display("[TB] FAIL wrap_err got=%b want=1", e); end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (dut.u_bytearray.mem_q[addrs[k]] !== refMem[0][addrs[k]]) begin
            bad++; $display("[TB] FAIL wrap_unchanged%0d got=%h want=%h", k,
                            dut.u_bytearray.mem_q[addrs[k]], refMem[0][addrs[k]]);
         end
      end
`else
      for (int k = 0; k < 4; k++) begin
         total++;
         if (dut.u_bytearray.mem_q[addrs[k]] !== exp8[k]) begin
            bad++; $display("[TB] FAIL wrap_byte%0d got=%h want=%h", k,
                            dut.u_bytearray.mem_q[addrs[k]], exp8[k]);
         end
      end
      applyTxn(1'b0, 32'd30, 32'd0, 0, d, e, l);
      total++;
      if (d !== 32'h11223344 || e !== 1'b0) begin
         bad++; $display("[TB] FAIL wrap_read got=%h e=%b want=11223344 0", d, e);
      end
`endif
   endtask

   task automatic test_backpressure();
      logic [31:0] d; logic e; int l;
      sel0 = 1'b0;
      applyTxn(1'b1, 32'h0C, 32'h0000000A, 0, d, e, l);
      applyTxn(1'b0, 32'h0C, 32'd0, 5, d, e, l);
      total++;
      if (d !== 32'h0000000A) begin
         bad++; $display("[TB] FAIL backpressure_data got=%h want=0000000a", d);
      end
   endtask

   task automatic test_latency0();
      logic [31:0] d; logic e; int l;
      logic [31:0] want;
      sel0 = 1'b1;
      applyTxn(1'b0, 32'h10, 32'd0, 0, d, e, l);
      want = modelRead(1, 32'h10);
      total++;
      if (l !== 1 || d !== want) begin
         bad++; $display("[TB] FAIL lat0_read lat=%0d d=%h want 1 %h", l, d, want);
      end
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h14;
      want = modelRead(1, 32'h14);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (rspValidM !== 1'b1 || reqReadyM !== 1'b0 || rspRdataM !== want) begin
            bad++; $display("[TB] FAIL lat0_held%0d v=%b rdy=%b d=%h want 1 0 %h",
                            i, rspValidM, reqReadyM, rspRdataM, want);
         end
      end
      rspReady = 1'b1;
      @(posedge clk); #1 rspReady = 1'b0;
      @(negedge clk);
      total++;
      if (rspValidM !== 1'b0 || reqReadyM !== 1'b1) begin
         bad++; $display("[TB] FAIL lat0_rearm v=%b rdy=%b want 0 1", rspValidM, reqReadyM);
      end
      @(posedge clk); #1 reqValid = 1'b0;
      @(negedge clk);
      total++;
      if (rspValidM !== 1'b1 || rspRdataM !== want) begin
         bad++; $display("[TB] FAIL lat0_second v=%b d=%h want 1 %h", rspValidM, rspRdataM, want);
      end
      rspReady = 1'b1;
      @(posedge clk); #1 rspReady = 1'b0;
      sel0 = 1'b0;
   endtask

   task automatic test_reset_wait();
      logic [31:0] d; logic e; int l;
      logic [31:0] want = modelRead(0, 32'h04);
      sel0 = 1'b0;
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h04; reqWdata = ~want;
      @(posedge clk); #1 reqValid = 1'b0;
      @(negedge clk);
      rstN = 1'b0;
      #1;
      total++;
      if (rspValid2 !== 1'b0 || reqReady2 !== 1'b1) begin
         bad++; $display("[TB] FAIL reset_wait_outputs v=%b rdy=%b want 0 1", rspValid2, reqReady2);
      end
      @(negedge clk); @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         total++;
         if (dut.u_bytearray.mem_q[4 + k] !== refMem[0][4 + k]) begin
            bad++; $display("[TB] FAIL reset_wait_mem%0d got=%h want=%h", k,
                            dut.u_bytearray.mem_q[4 + k], refMem[0][4 + k]);
         end
      end
      rstN = 1'b1;
      applyTxn(1'b0, 32'h04, 32'd0, 0, d, e, l);
      total++;
      if (d !== want) begin bad++; $display("[TB] FAIL reset_wait_read got=%h want=%h", d, want); end
   endtask

   task automatic test_random();
      logic [31:0] d, a, wd, want; logic e, wr; int l, stall, idx;
      for (int i = 0; i < 40; i++) begin
         sel0 = 1'($urandom_range(0, 1));
         idx  = sel0 ? 1 : 0;
         wr   = 1'($urandom_range(0, 1));
         a    = 32'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         if ($urandom_range(0, 3) == 0) a[31:5] = 27'($urandom);
         wd    = $urandom;
         stall = $urandom_range(0, 3);
         want  = (wr || alignErr(a)) ? 32'd0 : modelRead(idx, a);
         applyTxn(wr, a, wd, stall, d, e, l);
         total++;
         if (d !== want || e !== alignErr(a) || l !== curLat() + 1) begin
            bad++; $display("[TB] FAIL random%0d wr=%b a=%h got d=%h e=%b lat=%0d want d=%h e=%b lat=%0d",
                            i, wr, a, d, e, l, want, alignErr(a), curLat() + 1);
         end
      end
      sel0 = 1'b0;
   endtask

`ifdef DATAMEM_ALIGN_CHECK_EN
   task automatic test_align_check();
      logic [31:0] d; logic e; int l;
      logic [31:0] before;
      sel0 = 1'b0;
      before = modelRead(0, 32'h06);
      applyTxn(1'b1, 32'h06, ~before, 0, d, e, l);
      total++;
      if (e !== 1'b1) begin bad++; $display("[TB] FAIL align_06 got=%b want=1", e); end
      total++;
      if ({dut.u_bytearray.mem_q[6], dut.u_bytearray.mem_q[7], dut.u_bytearray.mem_q[8],
           dut.u_bytearray.mem_q[9]} !== before) begin
         bad++; $display("[TB] FAIL align_06_mem want=%h", before);
      end
      applyTxn(1'b1, 32'h40, 32'h12345678, 0, d, e, l);
      total++;
      if (e !== 1'b1) begin bad++; $display("[TB] FAIL align_40 got=%b want=1", e); end
      applyTxn(1'b1, 32'h04, 32'h12345678, 0, d, e, l);
      total++;
      if (e !== 1'b0) begin bad++; $display("[TB] FAIL align_04 got=%b want=0", e); end
   endtask
`endif

   initial begin
      for (int s = 0; s < 2; s++) for (int b = 0; b < 32; b++) refMem[s][b] = 8'h00;
      test_reset();
      initMem();
      test_store_load();
      test_wrap();
      test_backpressure();
      test_latency0();
      test_reset_wait();
`ifdef DATAMEM_ALIGN_CHECK_EN
      test_align_check();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
